eth_phy_10g_rx_link_ctrl: RTL and testbench

//  Link bring-up/recovery sequencer for the 10GBASE-R RX PHY path. Pulses SERDES RX reset, waits for block lock and

---
 rtl/eth_phy_10g_pkg.sv | 31 +++
 rtl/eth_phy_10g_rx_link_ctrl_if.sv | 33 +++
 rtl/eth_phy_10g_sat_acc.sv | 25 ++
 rtl/eth_phy_10g_rx_link_ctrl.sv | 113 +++++++++++
 tb/tb_eth_phy_10g_rx_link_ctrl.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/eth_phy_10g_pkg.sv
// Shared types and helpers for the 10GBASE-R RX link bring-up sequencer.
package eth_phy_10g_pkg;

    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_WAIT_STATUS = 3'd2,
        ST_UP          = 3'd3,
        ST_BACKOFF     = 3'd4,
        ST_PRBS        = 3'd5
    } link_state_t;

    // RX IF error pipeline is 2 deep; one more cycle for the enable to reach it.
    localparam int PRBS_SETTLE_CYCLES = 3;

    function automatic int unsigned timer_width(int unsigned lock_timeout,
                                                int unsigned reset_cycles,
                                                int unsigned max_shift);
        int unsigned m;
        m = reset_cycles << max_shift;
        if (lock_timeout > m) m = lock_timeout;
        return $clog2(m);
    endfunction

    function automatic int unsigned backoff_len(int unsigned base,
                                                int unsigned retry,
                                                int unsigned max_shift);
        return base << ((retry < max_shift) ? retry : max_shift);
    endfunction

endpackage

// File: rtl/eth_phy_10g_rx_link_ctrl_if.sv
// Status/control bundle between the RX link sequencer and its surroundings.
interface eth_phy_10g_rx_link_ctrl_if #(
    parameter int RETRY_WIDTH   = 8,
    parameter int ERR_ACC_WIDTH = 32
);
    logic                     rx_block_lock;
    logic                     rx_high_ber;
    logic                     rx_status;
    logic                     rx_reset_req;
    logic [6:0]               rx_error_count;
    logic                     cfg_prbs_req;
    logic                     cfg_err_clear;
    logic                     serdes_rx_reset;
    logic                     rx_prbs31_enable;
    logic                     link_up;
    logic                     prbs_active;
    logic [RETRY_WIDTH-1:0]   retry_count;
    logic [ERR_ACC_WIDTH-1:0] prbs_err_total;

    modport master (
        output rx_block_lock, rx_high_ber, rx_status, rx_reset_req, rx_error_count,
               cfg_prbs_req, cfg_err_clear,
        input  serdes_rx_reset, rx_prbs31_enable, link_up, prbs_active, retry_count,
               prbs_err_total
    );

    modport slave (
        input  rx_block_lock, rx_high_ber, rx_status, rx_reset_req, rx_error_count,
               cfg_prbs_req, cfg_err_clear,
        output serdes_rx_reset, rx_prbs31_enable, link_up, prbs_active, retry_count,
               prbs_err_total
    );
endinterface

// File: rtl/eth_phy_10g_sat_acc.sv
// Saturating accumulator with synchronous clear; clear beats add in the same cycle.
module eth_phy_10g_sat_acc #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                add,
    input  logic                clr,
    input  logic [IN_WIDTH-1:0] din,
    output logic [WIDTH-1:0]    acc
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, acc} + {{(WIDTH + 1 - IN_WIDTH){1'b0}}, din};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add)
            acc <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
endmodule

// File: rtl/eth_phy_10g_rx_link_ctrl.sv
// RX link bring-up/recovery sequencer with exponential backoff and PRBS31 test mode.
module eth_phy_10g_rx_link_ctrl
    import eth_phy_10g_pkg::*;
#(
    parameter int RESET_CYCLES      = 64,
    parameter int LOCK_TIMEOUT      = 65536,
    parameter int BACKOFF_MAX_SHIFT = 4,
    parameter int RETRY_WIDTH       = 8,
    parameter int ERR_ACC_WIDTH     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    eth_phy_10g_rx_link_ctrl_if.slave  bus
);
    localparam int TW = timer_width(LOCK_TIMEOUT, RESET_CYCLES, BACKOFF_MAX_SHIFT);

    link_state_t            state, nxt;
    logic [TW-1:0]          timer;
    logic [TW-1:0]          bo_last;
    logic                   serdes_rx_reset_q, prbs_en_q, link_up_q, prbs_active_q;
    logic [RETRY_WIDTH-1:0] retry_q;
    logic [ERR_ACC_WIDTH-1:0] err_total_q;
    logic                   enter_bo, enter_up;

    always_comb begin
        nxt = state;
        if (state != ST_PRBS && bus.cfg_prbs_req) begin
            nxt = ST_PRBS;
        end else begin
            case (state)
                ST_RESET:
                    if (timer == TW'(RESET_CYCLES - 1)) nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK:
                    if (bus.rx_reset_req)                    nxt = ST_BACKOFF;
                    else if (bus.rx_block_lock)              nxt = ST_WAIT_STATUS;
                    else if (timer == TW'(LOCK_TIMEOUT - 1)) nxt = ST_BACKOFF;
                ST_WAIT_STATUS:
                    if (bus.rx_reset_req)                    nxt = ST_BACKOFF;
                    else if (!bus.rx_block_lock)             nxt = ST_WAIT_LOCK;
                    else if (bus.rx_status)                  nxt = ST_UP;
                    else if (timer == TW'(LOCK_TIMEOUT - 1)) nxt = ST_BACKOFF;
                ST_UP:
                    if (bus.rx_reset_req)                        nxt = ST_BACKOFF;
                    else if (!bus.rx_block_lock)                 nxt = ST_WAIT_LOCK;
                    else if (!bus.rx_status || bus.rx_high_ber)  nxt = ST_WAIT_STATUS;
                ST_BACKOFF:
                    if (timer == bo_last) nxt = ST_RESET;
                ST_PRBS:
                    if (!bus.cfg_prbs_req) nxt = ST_RESET;
                default:
                    nxt = ST_RESET;
            endcase
        end
    end

    assign enter_bo = (nxt == ST_BACKOFF) && (state != ST_BACKOFF);
    assign enter_up = (nxt == ST_UP) && (state != ST_UP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_RESET;
            timer             <= '0;
            bo_last           <= '0;
            serdes_rx_reset_q <= 1'b1;
            prbs_en_q         <= 1'b0;
            link_up_q         <= 1'b0;
            prbs_active_q     <= 1'b0;
        end else begin
            state             <= nxt;
            serdes_rx_reset_q <= (nxt == ST_RESET);
            prbs_en_q         <= (nxt == ST_PRBS);
            link_up_q         <= (nxt == ST_UP);
            prbs_active_q     <= (state == ST_PRBS) && (nxt == ST_PRBS) &&
                                 (timer >= TW'(PRBS_SETTLE_CYCLES - 1));
            // Backoff length is latched from the pre-increment retry count.
            if (enter_bo)
                bo_last <= TW'(backoff_len(RESET_CYCLES, 32'(retry_q), BACKOFF_MAX_SHIFT) - 1);
            if (nxt != state)
                timer <= '0;
            else if (state == ST_PRBS)
                timer <= (timer < TW'(PRBS_SETTLE_CYCLES)) ? timer + 1'b1 : timer;
            else if (state == ST_UP)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    eth_phy_10g_sat_acc #(.WIDTH(RETRY_WIDTH), .IN_WIDTH(1)) u_retry_acc (
        .clk (clk),
        .rst (rst),
        .add (enter_bo),
        .clr (enter_up),
        .din (1'b1),
        .acc (retry_q)
    );

    eth_phy_10g_sat_acc #(.WIDTH(ERR_ACC_WIDTH), .IN_WIDTH(7)) u_err_acc (
        .clk (clk),
        .rst (rst),
        .add ((state == ST_PRBS) && prbs_active_q),
        .clr (bus.cfg_err_clear),
        .din (bus.rx_error_count),
        .acc (err_total_q)
    );

    assign bus.serdes_rx_reset  = serdes_rx_reset_q;
    assign bus.rx_prbs31_enable = prbs_en_q;
    assign bus.link_up          = link_up_q;
    assign bus.prbs_active      = prbs_active_q;
    assign bus.retry_count      = retry_q;
    assign bus.prbs_err_total   = err_total_q;
endmodule

// File: tb/tb_eth_phy_10g_rx_link_ctrl.sv
// Directed vector bench for the RX link sequencer (RESET_CYCLES=8, LOCK_TIMEOUT=100, shift cap 2).
module tb_eth_phy_10g_rx_link_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    eth_phy_10g_rx_link_ctrl_if #(.RETRY_WIDTH(8), .ERR_ACC_WIDTH(8)) bus ();

    eth_phy_10g_rx_link_ctrl #(
        .RESET_CYCLES(8), .LOCK_TIMEOUT(100), .BACKOFF_MAX_SHIFT(2),
        .RETRY_WIDTH(8), .ERR_ACC_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // in = {lock, status, high_ber, reset_req, prbs_req, err_clear}
    // ex = {serdes_rx_reset, prbs31_enable, link_up, prbs_active}
    typedef struct {
        string      name;
        int         n;
        logic [5:0] in;
        logic [6:0] errc;
        logic [3:0] ex;
        logic [7:0] retry;
        logic [7:0] tot;
    } vec_t;

    vec_t bring[$];
    vec_t prbs[$];

    function automatic vec_t mk(string name, int n, logic [5:0] in, logic [6:0] errc,
                                logic [3:0] ex, logic [7:0] retry, logic [7:0] tot);
        vec_t v;
        v.name = name; v.n = n; v.in = in; v.errc = errc;
        v.ex = ex; v.retry = retry; v.tot = tot;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string name, logic [3:0] ex, logic [7:0] retry, logic [7:0] tot);
        chk({name, ".serdes_rx_reset"},  32'(bus.serdes_rx_reset),  32'(ex[3]));
        chk({name, ".rx_prbs31_enable"}, 32'(bus.rx_prbs31_enable), 32'(ex[2]));
        chk({name, ".link_up"},          32'(bus.link_up),          32'(ex[1]));
        chk({name, ".prbs_active"},      32'(bus.prbs_active),      32'(ex[0]));
        chk({name, ".retry_count"},      32'(bus.retry_count),      32'(retry));
        chk({name, ".prbs_err_total"},   32'(bus.prbs_err_total),   32'(tot));
    endtask

    task automatic drive(logic [5:0] in, logic [6:0] errc);
        {bus.rx_block_lock, bus.rx_status, bus.rx_high_ber, bus.rx_reset_req,
         bus.cfg_prbs_req, bus.cfg_err_clear} = in;
        bus.rx_error_count = errc;
    endtask

    task automatic run_row(vec_t v);
        drive(v.in, v.errc);
        repeat (v.n) @(posedge clk);
        #1;
        chk_all(v.name, v.ex, v.retry, v.tot);
    endtask

    // Leaves the bench at 1 time unit after an edge with rst low: cycle 0.
    task automatic reset_release();
        rst = 1'b1;
        drive(6'b0, 7'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("in_reset", 4'b1000, 8'd0, 8'd0);
        rst = 1'b0;
    endtask

    initial begin
        drive(6'b0, 7'd0);

        // Bring-up, recovery, then repeated lock timeouts with growing backoff.
        bring.push_back(mk("rst_hold7",   7,   6'b000000, 0, 4'b1000, 0, 0));
        bring.push_back(mk("rst_done",    1,   6'b000000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("wait_lock",   12,  6'b000000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("wait_status", 10,  6'b100000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("up31",        1,   6'b110000, 0, 4'b0010, 0, 0));
        bring.push_back(mk("reset_req",   1,   6'b110100, 0, 4'b0000, 1, 0));
        bring.push_back(mk("bo1_end",     7,   6'b110000, 0, 4'b0000, 1, 0));
        bring.push_back(mk("bo1_reset",   1,   6'b110000, 0, 4'b1000, 1, 0));
        bring.push_back(mk("relock",      9,   6'b110000, 0, 4'b0000, 1, 0));
        bring.push_back(mk("up_clr",      1,   6'b110000, 0, 4'b0010, 0, 0));
        bring.push_back(mk("high_ber",    1,   6'b111000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("up_again",    1,   6'b110000, 0, 4'b0010, 0, 0));
        bring.push_back(mk("lost_lock",   1,   6'b010000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("to1_pre",     99,  6'b000000, 0, 4'b0000, 0, 0));
        bring.push_back(mk("to1",         1,   6'b000000, 0, 4'b0000, 1, 0));
        bring.push_back(mk("bo8_end",     7,   6'b000000, 0, 4'b0000, 1, 0));
        bring.push_back(mk("bo8_reset",   1,   6'b000000, 0, 4'b1000, 1, 0));
        bring.push_back(mk("to2_pre",     107, 6'b000000, 0, 4'b0000, 1, 0));
        bring.push_back(mk("to2",         1,   6'b000000, 0, 4'b0000, 2, 0));
        bring.push_back(mk("bo16_end",    15,  6'b000000, 0, 4'b0000, 2, 0));
        bring.push_back(mk("bo16_reset",  1,   6'b000000, 0, 4'b1000, 2, 0));
        bring.push_back(mk("to3_pre",     107, 6'b000000, 0, 4'b0000, 2, 0));
        bring.push_back(mk("to3",         1,   6'b000000, 0, 4'b0000, 3, 0));
        bring.push_back(mk("bo32_end",    31,  6'b000000, 0, 4'b0000, 3, 0));
        bring.push_back(mk("bo32_reset",  1,   6'b000000, 0, 4'b1000, 3, 0));
        bring.push_back(mk("to4_pre",     107, 6'b000000, 0, 4'b0000, 3, 0));
        bring.push_back(mk("to4",         1,   6'b000000, 0, 4'b0000, 4, 0));
        bring.push_back(mk("bo32c_end",   31,  6'b000000, 0, 4'b0000, 4, 0));
        bring.push_back(mk("bo32c_reset", 1,   6'b000000, 0, 4'b1000, 4, 0));
        bring.push_back(mk("to5_pre",     107, 6'b000000, 0, 4'b0000, 4, 0));
        bring.push_back(mk("to5",         1,   6'b000000, 0, 4'b0000, 5, 0));

        // PRBS entry from RESET at cycle 0, settle, accumulate, clear, saturate, exit.
        prbs.push_back(mk("prbs_en",      1, 6'b000010, 5,   4'b0100, 0, 0));
        prbs.push_back(mk("prbs_settle",  2, 6'b000010, 5,   4'b0100, 0, 0));
        prbs.push_back(mk("prbs_active",  1, 6'b000010, 5,   4'b0101, 0, 0));
        prbs.push_back(mk("prbs_first",   1, 6'b000010, 5,   4'b0101, 0, 5));
        prbs.push_back(mk("prbs_35",      6, 6'b000010, 5,   4'b0101, 0, 35));
        prbs.push_back(mk("clr_wins",     1, 6'b000011, 5,   4'b0101, 0, 0));
        prbs.push_back(mk("rreq_ignored", 1, 6'b000110, 100, 4'b0101, 0, 100));
        prbs.push_back(mk("acc_200",      1, 6'b000010, 100, 4'b0101, 0, 200));
        prbs.push_back(mk("acc_sat",      1, 6'b000010, 100, 4'b0101, 0, 255));
        prbs.push_back(mk("acc_hold",     2, 6'b000010, 100, 4'b0101, 0, 255));
        prbs.push_back(mk("prbs_exit",    1, 6'b000000, 0,   4'b1000, 0, 255));
        prbs.push_back(mk("post_reset",   8, 6'b000000, 0,   4'b0000, 0, 255));
        prbs.push_back(mk("idle_clear",   1, 6'b000001, 0,   4'b0000, 0, 0));

        reset_release();
        chk_all("cycle0", 4'b1000, 8'd0, 8'd0);
        foreach (bring[i]) run_row(bring[i]);

        // Asynchronous reset in the middle of a backoff wait.
        drive(6'b0, 7'd0);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all("async_rst_mid_bo", 4'b1000, 8'd0, 8'd0);

        reset_release();
        foreach (prbs[i]) run_row(prbs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
